// File: rtl/weight_bank_buffer.sv
// weight_bank_buffer: double-banked kernel weight store streaming one kernel per request over a valid/ready port.
// Define WEIGHT_PARITY_EN to add a per-word even-parity bit and a sticky par_err output.
module weight_bank_buffer #(
    parameter int DATA_W   = 8,
    parameter int NUM_KERN = 16,
    parameter int KERN_PIX = 36,
    localparam int KW = $clog2(NUM_KERN),
    localparam int PW = $clog2(KERN_PIX)
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              wr_en,
    input  logic [KW-1:0]     wr_kern,
    input  logic [PW-1:0]     wr_pix,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              swap,
    input  logic              rd_start,
    input  logic [KW-1:0]     rd_kern,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              active_bank
`ifdef WEIGHT_PARITY_EN
    ,
    output logic              par_err
`endif
);
`ifdef WEIGHT_PARITY_EN
    localparam int MW = DATA_W + 1;
`else
    localparam int MW = DATA_W;
`endif
    typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;
    state_t        state;
    logic [MW-1:0] mem [2][NUM_KERN][KERN_PIX];
    logic [KW-1:0] kern;
    logic [PW-1:0] pix;
    logic [PW-1:0] rd_pix;
    logic [MW-1:0] wr_word;
    logic [MW-1:0] rd_word;
    logic          pend;
    logic          wr_ok;
    logic          start_ok;
    logic          xfer;
    always_comb begin
        wr_ok    = wr_en && 32'(wr_kern) < NUM_KERN && 32'(wr_pix) < KERN_PIX;
        start_ok = rd_start && 32'(rd_kern) < NUM_KERN;
        xfer     = state == STREAM && out_valid && out_ready;
        // Prefetch address: pixel 0 while fetching, the following pixel while streaming.
        rd_pix   = state == STREAM ? pix + 1'b1 : pix;
        rd_word  = mem[active_bank][kern][rd_pix];
`ifdef WEIGHT_PARITY_EN
        wr_word  = {^wr_data, wr_data};
`else
        wr_word  = wr_data;
`endif
    end
    always_ff @(posedge Clk) begin
        if (wr_ok)
            mem[~active_bank][wr_kern][wr_pix] <= wr_word;
    end
`ifdef WEIGHT_PARITY_EN
    logic out_par;
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_par <= 1'b0;
            par_err <= 1'b0;
        end else begin
            if ((state == FETCH) || (xfer && !out_last))
                out_par <= rd_word[DATA_W];
            if (xfer && ^{out_par, out_data})
                par_err <= 1'b1;
        end
    end
`endif
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= IDLE;
            kern        <= '0;
            pix         <= '0;
            pend        <= 1'b0;
            active_bank <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (swap)
                        active_bank <= ~active_bank;
                    if (start_ok) begin
                        kern  <= rd_kern;
                        pix   <= '0;
                        busy  <= 1'b1;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (swap)
                        pend <= 1'b1;
                    out_data  <= rd_word[DATA_W-1:0];
                    out_valid <= 1'b1;
                    out_last  <= 1'b0;
                    state     <= STREAM;
                end
                STREAM: begin
                    if (swap)
                        pend <= 1'b1;
                    if (xfer && out_last) begin
                        // A swap requested during the stream lands on the return to IDLE.
                        active_bank <= active_bank ^ (pend | swap);
                        pend        <= 1'b0;
                        out_valid   <= 1'b0;
                        out_last    <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else if (xfer) begin
                        pix      <= pix + 1'b1;
                        out_data <= rd_word[DATA_W-1:0];
                        out_last <= 32'(pix) == KERN_PIX - 2;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/weight_bank_buffer.md
WEIGHT_BANK_BUFFER -- requirements
Module: weight_bank_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning weight word width in bits.
REQ-002 SHALL have parameter NUM_KERN, default 16, meaning kernels stored per bank.
REQ-003 SHALL have parameter KERN_PIX, default 36, meaning weight words per kernel (2..64).
REQ-004 SHALL derive KW = clog2(NUM_KERN) and PW = clog2(KERN_PIX) as localparams.
REQ-005 SHALL have Clk input, 1 bit: single clock; all state on rising edge.
REQ-006 SHALL have Rst_n input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 SHALL have wr_en input, 1 bit: write strobe into the shadow bank.
REQ-008 SHALL have wr_kern input, KW bits, and wr_pix input, PW bits: write address.
REQ-009 SHALL have wr_data input, DATA_W bits: write data.
REQ-010 SHALL have swap input, 1 bit: request exchange of active and shadow banks.
REQ-011 SHALL have rd_start input, 1 bit, and rd_kern input, KW bits: start streaming one kernel.
REQ-012 SHALL have out_data output, DATA_W bits, plus out_valid and out_last outputs, 1 bit each: stream.
REQ-013 SHALL have out_ready input, 1 bit: downstream accept.
REQ-014 SHALL have busy output, 1 bit, and active_bank output, 1 bit: status.

Function
REQ-015 SHALL hold two banks of NUM_KERN x KERN_PIX words; reads use the active bank, writes use the shadow bank.
REQ-016 SHALL write wr_data to shadow[wr_kern][wr_pix] on any cycle with wr_en=1, independent of stream state.
REQ-017 SHALL ignore writes with wr_kern >= NUM_KERN or wr_pix >= KERN_PIX.
REQ-018 SHALL implement FSM IDLE -> FETCH -> STREAM -> IDLE.
REQ-019 IDLE: rd_start=1 with rd_kern < NUM_KERN latches rd_kern, clears pixel counter, goes to FETCH; out-of-range rd_kern is ignored.
REQ-020 FETCH: one-cycle synchronous read of pixel 0; next state STREAM with out_valid=1 (first word 2 cycles after rd_start).
REQ-021 STREAM: word transfers when out_valid & out_ready; out_data, out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 SHALL prefetch the next word so back-to-back transfers occur every cycle with out_ready held high.
REQ-023 out_last SHALL be 1 exactly with pixel KERN_PIX-1; its transfer returns FSM to IDLE with out_valid=0.
REQ-024 busy SHALL be 1 in FETCH and STREAM, 0 in IDLE; rd_start while busy SHALL be ignored.
REQ-025 swap in IDLE SHALL toggle active_bank on that edge; swap while busy SHALL be held pending and applied on the cycle the FSM reaches IDLE.
REQ-026 Simultaneous swap and rd_start in IDLE: swap takes effect first; the stream reads the new active bank.
REQ-027 Simultaneous wr_en to the kernel being streamed SHALL not affect the stream (different bank).
REQ-028 Pixel counter SHALL not wrap; it saturates at KERN_PIX-1 and clears on entry to FETCH.

Reset
REQ-029 Rst_n=0 SHALL asynchronously force IDLE, out_valid=0, out_last=0, out_data=0, busy=0, active_bank=0, pending swap cleared.
REQ-030 Reset mid-stream SHALL abort the stream; memory contents are not cleared and are undefined until written.
REQ-031 Outputs SHALL leave reset values only on the first rising Clk edge after Rst_n deasserts.

Configuration
REQ-032 Macro WEIGHT_PARITY_EN defined: each word stores an extra even-parity bit computed at write; output par_err (1 bit) SHALL set sticky when a streamed word's parity mismatches, cleared only by reset.
REQ-033 Macro WEIGHT_PARITY_EN undefined: no parity storage, no par_err port; all other behaviour identical.

Verification
REQ-034 Reset, write shadow[3][0..35]=0x10+i, swap, rd_start kern 3, out_ready=1 -> 36 words 0x10..0x33 on consecutive cycles, first 2 cycles after start, out_last only on 0x33.
REQ-035 Same stream with out_ready toggling 1,0,0,1 -> no word lost or duplicated, out_data stable during stalls.
REQ-036 swap asserted mid-stream -> active_bank unchanged until out_last transfer, toggles on the IDLE cycle; current stream data all from old bank.
REQ-037 Rst_n pulsed low at word 10 -> out_valid=0, busy=0, active_bank=0 immediately; rd_start after release restarts at pixel 0.
REQ-038 rd_kern=NUM_KERN and wr_pix=KERN_PIX -> no stream started, busy stays 0, no memory corruption on readback.
REQ-039 With WEIGHT_PARITY_EN, force a stored parity bit flip, stream that kernel -> par_err=1 the cycle after the bad word transfers, stays 1 until reset.
